store_rmw_unit: RTL and testbench

Memory-side store engine for the multicycle core. It is the write-direction counterpart of the load-side byte/halfword extraction.
- Accepts word, halfword and byte store requests.
- Word stores are written directly.
- Sub-word stores use a read-modify-write over the single-port synchronous memory interface (address, wr, data in, data out).
- Sits between the control FSM / ALUOut address path and the memory.

---
 rtl/store_pkg.sv | 20 ++
 rtl/store_rmw_unit_if.sv | 24 ++
 rtl/store_lane_merge.sv | 30 +++
 rtl/store_rmw_unit.sv | 81 ++++++++
 tb/tb_store_rmw_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/store_pkg.sv
// Shared encodings and helpers for the store read-modify-write engine.
package store_pkg;

  localparam logic [1:0] SZ_WORD    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_BYTE    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, ERR} state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_WORD: return (addr_lo != 2'b00);
      SZ_HALF: return addr_lo[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Request and single-port memory signals of the store engine; slave = the unit.
interface store_rmw_unit_if;
  logic        req_valid;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;

  modport master (
    output req_valid, req_size, req_addr, req_data, mem_dataout,
    input  busy, done, error, mem_addr, mem_wr, mem_datain
  );

  modport slave (
    input  req_valid, req_size, req_addr, req_data, mem_dataout,
    output busy, done, error, mem_addr, mem_wr, mem_datain
  );
endinterface

// File: rtl/store_lane_merge.sv
// Combinational insertion of a byte or halfword into the word read back from memory.
module store_lane_merge
  import store_pkg::*;
#(
  parameter int unsigned BIG_ENDIAN = 0
) (
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  logic [1:0] lane;
  logic       half;

  always_comb begin
    merged = old_word;
    // Big-endian mirrors the lane index so address 0 lands in the top bits
    lane   = (BIG_ENDIAN != 0) ? ~addr_lo : addr_lo;
    half   = (BIG_ENDIAN != 0) ? ~addr_lo[1] : addr_lo[1];
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8]  = data[7:0];
      SZ_HALF: merged[{half, 4'b0000} +: 16] = data[15:0];
      SZ_WORD: merged = data;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store engine: word stores written directly, sub-word stores via read-modify-write.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned BIG_ENDIAN   = 0
) (
  input  logic             Clk,
  input  logic             reset,
  store_rmw_unit_if.slave  bus
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  state_t      state, state_next;
  logic [31:0] addr_q, data_q, merged_q, merged_w;
  logic [1:0]  size_q;
  logic [2:0]  cnt;

  store_lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_merge (
    .old_word (bus.mem_dataout),
    .data     (data_q),
    .size     (size_q),
    .addr_lo  (addr_q[1:0]),
    .merged   (merged_w)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= SZ_WORD;
      merged_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (bus.req_valid) begin
          addr_q <= bus.req_addr;
          data_q <= bus.req_data;
          size_q <= bus.req_size;
          cnt    <= '0;
        end
        READ:    cnt      <= cnt + 3'd1;
        CAPTURE: merged_q <= merged_w;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.req_valid) begin
        if (is_misaligned(bus.req_size, bus.req_addr[1:0])) state_next = ERR;
        else if (bus.req_size == SZ_WORD)                    state_next = WRITE;
        else                                                 state_next = READ;
      end
      READ:    if (cnt == LAT_LAST) state_next = CAPTURE;
      CAPTURE: state_next = WRITE;
      WRITE:   state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state != IDLE);
    bus.done       = (state == WRITE);
    bus.error      = (state == ERR);
    bus.mem_wr     = (state == WRITE);
    bus.mem_addr   = '0;
    bus.mem_datain = '0;
    if (state == READ || state == CAPTURE || state == WRITE)
      bus.mem_addr = {addr_q[31:2], 2'b00};
    if (state == WRITE)
      bus.mem_datain = (size_q == SZ_WORD) ? data_q : merged_q;
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed checks of the store engine against small behavioural memories.
module tb_store_rmw_unit;

  logic Clk = 1'b0;
  logic rst = 1'b0;
  logic init_mem = 1'b0;
  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 Clk = ~Clk;

  store_rmw_unit_if u0 ();
  store_rmw_unit_if u1 ();
  store_rmw_unit_if u2 ();

  store_rmw_unit #(.READ_LATENCY(1), .BIG_ENDIAN(0)) dut0 (.Clk(Clk), .reset(rst), .bus(u0));
  store_rmw_unit #(.READ_LATENCY(1), .BIG_ENDIAN(1)) dut1 (.Clk(Clk), .reset(rst), .bus(u1));
  store_rmw_unit #(.READ_LATENCY(3), .BIG_ENDIAN(0)) dut2 (.Clk(Clk), .reset(rst), .bus(u2));

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic [31:0] mem2 [0:255];
  logic [31:0] p0, p1, p2a, p2b, p2c;
  int unsigned wr0 = 0;

  always @(posedge Clk) begin
    if (init_mem) mem0[64] <= 32'hAABBCCDD;
    else if (u0.mem_wr) begin
      mem0[u0.mem_addr[9:2]] <= u0.mem_datain;
      wr0 <= wr0 + 1;
    end
    p0 <= mem0[u0.mem_addr[9:2]];
  end
  assign u0.mem_dataout = p0;

  always @(posedge Clk) begin
    if (init_mem) mem1[64] <= 32'hAABBCCDD;
    else if (u1.mem_wr) mem1[u1.mem_addr[9:2]] <= u1.mem_datain;
    p1 <= mem1[u1.mem_addr[9:2]];
  end
  assign u1.mem_dataout = p1;

  always @(posedge Clk) begin
    if (init_mem) mem2[64] <= 32'hAABBCCDD;
    else if (u2.mem_wr) mem2[u2.mem_addr[9:2]] <= u2.mem_datain;
    p2a <= mem2[u2.mem_addr[9:2]];
    p2b <= p2a;
    p2c <= p2b;
  end
  assign u2.mem_dataout = p2c;

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    init_mem = 1'b1;
    next_cycle();
    init_mem = 1'b0;
  endtask

  task automatic req0(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    u0.req_valid = 1'b1;
    u0.req_size  = size;
    u0.req_addr  = addr;
    u0.req_data  = data;
  endtask

  int unsigned wr_snap;

  initial begin
    u0.req_valid = 0; u0.req_size = 0; u0.req_addr = 0; u0.req_data = 0;
    u1.req_valid = 0; u1.req_size = 0; u1.req_addr = 0; u1.req_data = 0;
    u2.req_valid = 0; u2.req_size = 0; u2.req_addr = 0; u2.req_data = 0;

    // Reset state
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    check("rst_busy", {31'd0, u0.busy}, 32'd0);
    check("rst_done", {31'd0, u0.done}, 32'd0);
    check("rst_error", {31'd0, u0.error}, 32'd0);
    check("rst_mem_wr", {31'd0, u0.mem_wr}, 32'd0);
    check("rst_mem_addr", u0.mem_addr, 32'd0);
    check("rst_mem_datain", u0.mem_datain, 32'd0);
    check("rst_busy_be", {31'd0, u1.busy}, 32'd0);
    check("rst_busy_l3", {31'd0, u2.busy}, 32'd0);

    // Word store
    load_mem();
    req0(2'b00, 32'h100, 32'h12345678);
    next_cycle();
    u0.req_valid = 1'b0;
    check("word_mem_wr", {31'd0, u0.mem_wr}, 32'd1);
    check("word_mem_addr", u0.mem_addr, 32'h100);
    check("word_datain", u0.mem_datain, 32'h12345678);
    check("word_done", {31'd0, u0.done}, 32'd1);
    check("word_busy", {31'd0, u0.busy}, 32'd1);
    next_cycle();
    check("word_busy_after", {31'd0, u0.busy}, 32'd0);
    check("word_datain_idle", u0.mem_datain, 32'd0);
    check("word_mem", mem0[64], 32'h12345678);

    // Byte store LE
    load_mem();
    req0(2'b10, 32'h102, 32'h000000EE);
    next_cycle();
    u0.req_valid = 1'b0;
    check("byte_c1_mem_wr", {31'd0, u0.mem_wr}, 32'd0);
    check("byte_c1_mem_addr", u0.mem_addr, 32'h100);
    check("byte_c1_busy", {31'd0, u0.busy}, 32'd1);
    next_cycle();
    check("byte_c2_mem_wr", {31'd0, u0.mem_wr}, 32'd0);
    check("byte_c2_done", {31'd0, u0.done}, 32'd0);
    next_cycle();
    check("byte_c3_mem_wr", {31'd0, u0.mem_wr}, 32'd1);
    check("byte_c3_datain", u0.mem_datain, 32'hAAEECCDD);
    check("byte_c3_done", {31'd0, u0.done}, 32'd1);
    next_cycle();
    check("byte_mem", mem0[64], 32'hAAEECCDD);
    check("byte_idle_addr", u0.mem_addr, 32'd0);

    // Halfword store LE
    load_mem();
    req0(2'b01, 32'h102, 32'h1111BEEF);
    next_cycle();
    u0.req_valid = 1'b0;
    next_cycle();
    next_cycle();
    check("half_c3_datain", u0.mem_datain, 32'hBEEFCCDD);
    check("half_c3_done", {31'd0, u0.done}, 32'd1);
    next_cycle();
    check("half_mem", mem0[64], 32'hBEEFCCDD);

    // Halfword store BE
    load_mem();
    u1.req_valid = 1'b1; u1.req_size = 2'b01; u1.req_addr = 32'h102; u1.req_data = 32'h1111BEEF;
    next_cycle();
    u1.req_valid = 1'b0;
    next_cycle();
    next_cycle();
    check("half_be_datain", u1.mem_datain, 32'hAABBBEEF);
    check("half_be_done", {31'd0, u1.done}, 32'd1);
    next_cycle();
    check("half_be_mem", mem1[64], 32'hAABBBEEF);

    // Misaligned half, illegal size, misaligned word
    load_mem();
    wr_snap = wr0;
    req0(2'b01, 32'h101, 32'h0000BEEF);
    next_cycle();
    u0.req_valid = 1'b0;
    check("mis_half_error", {31'd0, u0.error}, 32'd1);
    check("mis_half_done", {31'd0, u0.done}, 32'd0);
    check("mis_half_mem_wr", {31'd0, u0.mem_wr}, 32'd0);
    next_cycle();
    check("mis_half_error_pulse", {31'd0, u0.error}, 32'd0);
    check("mis_half_busy", {31'd0, u0.busy}, 32'd0);
    req0(2'b11, 32'h100, 32'h0000BEEF);
    next_cycle();
    u0.req_valid = 1'b0;
    check("illegal_error", {31'd0, u0.error}, 32'd1);
    check("illegal_done", {31'd0, u0.done}, 32'd0);
    next_cycle();
    req0(2'b00, 32'h102, 32'h12345678);
    next_cycle();
    u0.req_valid = 1'b0;
    check("mis_word_error", {31'd0, u0.error}, 32'd1);
    next_cycle();
    check("mis_no_writes", wr0, wr_snap);
    check("mis_mem", mem0[64], 32'hAABBCCDD);

    // Request held high, data changed mid-operation
    load_mem();
    req0(2'b10, 32'h103, 32'h00000055);
    next_cycle();
    u0.req_addr = 32'h100;
    u0.req_data = 32'h00000066;
    check("hold_c1_mem_wr", {31'd0, u0.mem_wr}, 32'd0);
    next_cycle();
    next_cycle();
    check("hold_c3_datain", u0.mem_datain, 32'h55BBCCDD);
    check("hold_c3_done", {31'd0, u0.done}, 32'd1);
    next_cycle();
    check("hold_c4_busy", {31'd0, u0.busy}, 32'd0);
    check("hold_c4_mem", mem0[64], 32'h55BBCCDD);
    next_cycle();
    u0.req_valid = 1'b0;
    check("hold_c5_busy", {31'd0, u0.busy}, 32'd1);
    check("hold_c5_mem_wr", {31'd0, u0.mem_wr}, 32'd0);
    next_cycle();
    next_cycle();
    check("hold_c7_datain", u0.mem_datain, 32'h55BBCC66);
    check("hold_c7_done", {31'd0, u0.done}, 32'd1);
    next_cycle();
    check("hold_mem", mem0[64], 32'h55BBCC66);

    // Reset during READ aborts
    load_mem();
    wr_snap = wr0;
    req0(2'b10, 32'h100, 32'h00000077);
    next_cycle();
    u0.req_valid = 1'b0;
    check("abort_in_read", {31'd0, u0.busy}, 32'd1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("abort_busy", {31'd0, u0.busy}, 32'd0);
    check("abort_mem_wr", {31'd0, u0.mem_wr}, 32'd0);
    next_cycle();
    next_cycle();
    check("abort_no_writes", wr0, wr_snap);
    check("abort_mem", mem0[64], 32'hAABBCCDD);

    // READ_LATENCY=3 byte store
    load_mem();
    u2.req_valid = 1'b1; u2.req_size = 2'b10; u2.req_addr = 32'h102; u2.req_data = 32'h000000EE;
    next_cycle();
    u2.req_valid = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    check("l3_c4_mem_wr", {31'd0, u2.mem_wr}, 32'd0);
    check("l3_c4_done", {31'd0, u2.done}, 32'd0);
    check("l3_c4_busy", {31'd0, u2.busy}, 32'd1);
    next_cycle();
    check("l3_c5_mem_wr", {31'd0, u2.mem_wr}, 32'd1);
    check("l3_c5_datain", u2.mem_datain, 32'hAAEECCDD);
    check("l3_c5_done", {31'd0, u2.done}, 32'd1);
    next_cycle();
    check("l3_mem", mem2[64], 32'hAAEECCDD);
    check("l3_busy_after", {31'd0, u2.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
